// File: rtl/layer_compositor.sv
// rtl/layer_compositor.sv - priority/OR layer compositor with per-pair overlap matrix
// Collision matrix compiled in only when LAYER_COMPOSITOR_COLLIDE_EN is defined.
module layer_compositor #(
  parameter int NUM_LAYERS = 4,
  parameter int BLEND_MODE = 0,
  parameter int NUM_PAIRS  = NUM_LAYERS * (NUM_LAYERS - 1) / 2
) (
  input  logic                     pixel_clk,
  input  logic                     rst_n,
  input  logic                     fsync,
  input  logic                     active,
  input  logic [NUM_LAYERS-1:0]    layer_active,
  input  logic [NUM_LAYERS*24-1:0] layer_pixel,
  input  logic                     override_en,
  input  logic [23:0]              override_pixel,
  output logic [23:0]              pixel_out,
  output logic [NUM_PAIRS-1:0]     collide_frame,
  output logic                     collide_pulse
);

  if (NUM_LAYERS < 2 || NUM_LAYERS > 8) begin : g_bad_num_layers
    $error("layer_compositor: NUM_LAYERS must be in 2..8");
  end

  logic                     s1_active;
  logic [NUM_LAYERS-1:0]    s1_layer_active;
  logic [NUM_LAYERS*24-1:0] s1_layer_pixel;
  logic                     s1_override_en;
  logic [23:0]              s1_override_pixel;
  logic [23:0]              blend;
  logic [23:0]              pixel_next;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_active         <= 1'b0;
      s1_layer_active   <= '0;
      s1_layer_pixel    <= '0;
      s1_override_en    <= 1'b0;
      s1_override_pixel <= '0;
    end else begin
      s1_active         <= active;
      s1_layer_active   <= layer_active;
      s1_layer_pixel    <= layer_pixel;
      s1_override_en    <= override_en;
      s1_override_pixel <= override_pixel;
    end
  end

  // Priority walks from the top index down so the lowest active index is written last.
  always_comb begin
    blend = '0;
    if (BLEND_MODE == 0) begin
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
        if (s1_layer_active[i]) blend = s1_layer_pixel[24*i +: 24];
      end
    end else begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (s1_layer_active[i]) blend = blend | s1_layer_pixel[24*i +: 24];
      end
    end
  end

  always_comb begin
    pixel_next = '0;
    if (s1_override_en)   pixel_next = s1_override_pixel;
    else if (s1_active)   pixel_next = blend;
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) pixel_out <= '0;
    else        pixel_out <= pixel_next;
  end

`ifdef LAYER_COMPOSITOR_COLLIDE_EN
  logic [NUM_PAIRS-1:0] hit;
  logic [NUM_PAIRS-1:0] acc;
  logic [NUM_PAIRS-1:0] frame_next;

  // Row-major upper-triangle pair indexing; override does not mask detection.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      for (int j = i + 1; j < NUM_LAYERS; j++) begin
        hit[i*NUM_LAYERS - i*(i+1)/2 + (j-i-1)] =
          s1_active & s1_layer_active[i] & s1_layer_active[j];
      end
    end
  end

  assign frame_next = acc | hit;

  // The fsync-cycle hit goes into the closing frame only, never into the new one.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      acc           <= '0;
      collide_frame <= '0;
      collide_pulse <= 1'b0;
    end else if (fsync) begin
      acc           <= '0;
      collide_frame <= frame_next;
      collide_pulse <= |frame_next;
    end else begin
      acc           <= frame_next;
      collide_pulse <= 1'b0;
    end
  end
`else
  logic unused_fsync;
  assign unused_fsync  = fsync;
  assign collide_frame = '0;
  assign collide_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_layer_compositor.sv
// tb/tb_layer_compositor.sv - directed bench for layer_compositor (priority and OR builds)
module tb_layer_compositor;

`ifdef LAYER_COMPOSITOR_COLLIDE_EN
  localparam bit COL_EN = 1'b1;
`else
  localparam bit COL_EN = 1'b0;
`endif

  logic        pixel_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fsync = 1'b0;
  logic        active = 1'b0;
  logic [3:0]  layer_active = '0;
  logic [95:0] layer_pixel = '0;
  logic        override_en = 1'b0;
  logic [23:0] override_pixel = '0;

  logic [23:0] pix_pri, pix_or;
  logic [5:0]  cf_pri, cf_or;
  logic        cp_pri, cp_or;

  int errors = 0;
  int checks = 0;

  always #5 pixel_clk = ~pixel_clk;

  layer_compositor #(.NUM_LAYERS(4), .BLEND_MODE(0)) dut_pri (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .fsync(fsync), .active(active),
    .layer_active(layer_active), .layer_pixel(layer_pixel),
    .override_en(override_en), .override_pixel(override_pixel),
    .pixel_out(pix_pri), .collide_frame(cf_pri), .collide_pulse(cp_pri)
  );

  layer_compositor #(.NUM_LAYERS(4), .BLEND_MODE(1)) dut_or (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .fsync(fsync), .active(active),
    .layer_active(layer_active), .layer_pixel(layer_pixel),
    .override_en(override_en), .override_pixel(override_pixel),
    .pixel_out(pix_or), .collide_frame(cf_or), .collide_pulse(cp_or)
  );

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic [3:0] la,
                       input logic [23:0] l0, input logic [23:0] l1,
                       input logic [23:0] l2, input logic [23:0] l3,
                       input logic oe, input logic [23:0] op);
    active = a;
    layer_active = la;
    layer_pixel = {l3, l2, l1, l0};
    override_en = oe;
    override_pixel = op;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (pix_pri !== 24'h0) begin errors++; $display("FAIL reset_pix: got %h want 000000", pix_pri); end
    checks++; if (cf_pri !== 6'h0) begin errors++; $display("FAIL reset_cf: got %b want 000000", cf_pri); end
    checks++; if (cp_pri !== 1'b0) begin errors++; $display("FAIL reset_cp: got %b want 0", cp_pri); end
    tick();
    rst_n = 1'b1;
    // build a nonzero collide_frame and a pending accumulator bit, then reset mid-stream
    drive(1, 4'b1001, 24'h111111, 24'h0, 24'h0, 24'h222222, 0, 24'h0);
    tick();
    fsync = 1'b1;
    tick();
    fsync = 1'b0;
    tick();
    checks++; if (pix_pri !== 24'h111111) begin errors++; $display("FAIL pre_reset_pix: got %h want 111111", pix_pri); end
    checks++; if (cf_pri !== (COL_EN ? 6'b000100 : 6'b0)) begin errors++; $display("FAIL pre_reset_cf: got %b want %b", cf_pri, (COL_EN ? 6'b000100 : 6'b0)); end
    rst_n = 1'b0;
    #1;
    checks++; if (pix_pri !== 24'h0 || pix_or !== 24'h0) begin errors++; $display("FAIL async_reset_pix: got %h/%h want 000000", pix_pri, pix_or); end
    checks++; if (cf_pri !== 6'h0) begin errors++; $display("FAIL async_reset_cf: got %b want 000000", cf_pri); end
    checks++; if (cp_pri !== 1'b0) begin errors++; $display("FAIL async_reset_cp: got %b want 0", cp_pri); end
    tick();
    rst_n = 1'b1;
    drive(1, 4'b0001, 24'hABCDEF, 24'h0, 24'h0, 24'h0, 0, 24'h0);
    tick();
    checks++; if (pix_pri !== 24'h0) begin errors++; $display("FAIL resume_lat1: got %h want 000000", pix_pri); end
    tick();
    checks++; if (pix_pri !== 24'hABCDEF) begin errors++; $display("FAIL resume_lat2: got %h want abcdef", pix_pri); end
    drive(0, 4'b0000, 24'h0, 24'h0, 24'h0, 24'h0, 0, 24'h0);
    fsync = 1'b1;
    tick();
    fsync = 1'b0;
    checks++; if (cf_pri !== 6'h0 || cp_pri !== 1'b0) begin errors++; $display("FAIL reset_discard: got cf=%b cp=%b want 000000/0", cf_pri, cp_pri); end
  endtask

  task automatic test_blend();
    drive(1, 4'b0110, 24'h0000AA, 24'hFF0000, 24'h00FF00, 24'h0000FF, 0, 24'h0);
    tick(); tick();
    checks++; if (pix_pri !== 24'hFF0000) begin errors++; $display("FAIL prio_0110: got %h want ff0000", pix_pri); end
    checks++; if (pix_or !== 24'hFFFF00) begin errors++; $display("FAIL or_0110: got %h want ffff00", pix_or); end
    drive(1, 4'b1000, 24'h0000AA, 24'hFF0000, 24'h00FF00, 24'h0000FF, 0, 24'h0);
    tick(); tick();
    checks++; if (pix_pri !== 24'h0000FF || pix_or !== 24'h0000FF) begin errors++; $display("FAIL single_l3: got %h/%h want 0000ff", pix_pri, pix_or); end
    drive(1, 4'b1111, 24'h010203, 24'h100000, 24'h002000, 24'h000030, 0, 24'h0);
    tick(); tick();
    checks++; if (pix_pri !== 24'h010203) begin errors++; $display("FAIL prio_all: got %h want 010203", pix_pri); end
    checks++; if (pix_or !== 24'h112233) begin errors++; $display("FAIL or_all: got %h want 112233", pix_or); end
    drive(1, 4'b0000, 24'h010203, 24'h100000, 24'h002000, 24'h000030, 0, 24'h0);
    tick(); tick();
    checks++; if (pix_pri !== 24'h0 || pix_or !== 24'h0) begin errors++; $display("FAIL none_active: got %h/%h want 000000", pix_pri, pix_or); end
  endtask

  task automatic test_override();
    drive(1, 4'b1111, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 1, 24'h123456);
    tick(); tick();
    checks++; if (pix_pri !== 24'h123456 || pix_or !== 24'h123456) begin errors++; $display("FAIL override: got %h/%h want 123456", pix_pri, pix_or); end
    drive(0, 4'b1111, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 0, 24'h123456);
    tick(); tick();
    checks++; if (pix_pri !== 24'h0 || pix_or !== 24'h0) begin errors++; $display("FAIL blanking: got %h/%h want 000000", pix_pri, pix_or); end
    drive(0, 4'b0000, 24'h0, 24'h0, 24'h0, 24'h0, 1, 24'h654321);
    tick(); tick();
    checks++; if (pix_pri !== 24'h654321) begin errors++; $display("FAIL override_blank: got %h want 654321", pix_pri); end
  endtask

  task automatic test_collision();
    drive(0, 4'b0000, 24'h0, 24'h0, 24'h0, 24'h0, 0, 24'h0);
    fsync = 1'b1; tick(); fsync = 1'b0; tick();
    drive(1, 4'b1001, 24'h0, 24'h0, 24'h0, 24'h0, 0, 24'h0);
    tick();
    drive(1, 4'b0001, 24'h0, 24'h0, 24'h0, 24'h0, 0, 24'h0);
    tick();
    fsync = 1'b1; tick(); fsync = 1'b0;
    checks++; if (cf_pri !== (COL_EN ? 6'b000100 : 6'b0)) begin errors++; $display("FAIL coll_frame: got %b want %b", cf_pri, (COL_EN ? 6'b000100 : 6'b0)); end
    checks++; if (cp_pri !== COL_EN) begin errors++; $display("FAIL coll_pulse: got %b want %b", cp_pri, COL_EN); end
    tick();
    checks++; if (cp_pri !== 1'b0) begin errors++; $display("FAIL coll_pulse_width: got %b want 0", cp_pri); end
    checks++; if (cf_or !== (COL_EN ? 6'b000100 : 6'b0)) begin errors++; $display("FAIL coll_hold: got %b want %b", cf_or, (COL_EN ? 6'b000100 : 6'b0)); end
    fsync = 1'b1; tick(); fsync = 1'b0;
    checks++; if (cf_pri !== 6'h0 || cp_pri !== 1'b0) begin errors++; $display("FAIL coll_empty: got cf=%b cp=%b want 000000/0", cf_pri, cp_pri); end
  endtask

  task automatic test_simultaneous();
    drive(1, 4'b0110, 24'h0, 24'h0, 24'h0, 24'h0, 0, 24'h0);
    tick();
    drive(1, 4'b0000, 24'h0, 24'h0, 24'h0, 24'h0, 0, 24'h0);
    fsync = 1'b1; tick(); fsync = 1'b0;
    checks++; if (cf_pri !== (COL_EN ? 6'b001000 : 6'b0) || cp_pri !== COL_EN) begin errors++; $display("FAIL simul_frame: got cf=%b cp=%b want %b/%b", cf_pri, cp_pri, (COL_EN ? 6'b001000 : 6'b0), COL_EN); end
    tick();
    fsync = 1'b1; tick(); fsync = 1'b0;
    checks++; if (cf_pri !== 6'h0 || cp_pri !== 1'b0) begin errors++; $display("FAIL simul_next: got cf=%b cp=%b want 000000/0", cf_pri, cp_pri); end
  endtask

  task automatic test_back_to_back();
    drive(1, 4'b0011, 24'h0, 24'h0, 24'h0, 24'h0, 0, 24'h0); tick();
    drive(1, 4'b1100, 24'h0, 24'h0, 24'h0, 24'h0, 0, 24'h0); tick();
    drive(1, 4'b0011, 24'h0, 24'h0, 24'h0, 24'h0, 0, 24'h0); tick();
    drive(0, 4'b0000, 24'h0, 24'h0, 24'h0, 24'h0, 0, 24'h0);
    for (int n = 0; n < 20; n++) tick();
    checks++; if (cf_pri !== 6'h0) begin errors++; $display("FAIL no_fsync_hold: got %b want 000000", cf_pri); end
    drive(1, 4'b0101, 24'h0, 24'h0, 24'h0, 24'h0, 0, 24'h0);
    fsync = 1'b1; tick();
    checks++; if (cf_pri !== (COL_EN ? 6'b100001 : 6'b0) || cp_pri !== COL_EN) begin errors++; $display("FAIL sat_frame: got cf=%b cp=%b want %b/%b", cf_pri, cp_pri, (COL_EN ? 6'b100001 : 6'b0), COL_EN); end
    drive(0, 4'b0000, 24'h0, 24'h0, 24'h0, 24'h0, 0, 24'h0);
    tick(); fsync = 1'b0;
    checks++; if (cf_pri !== (COL_EN ? 6'b000010 : 6'b0) || cp_pri !== COL_EN) begin errors++; $display("FAIL b2b_frame: got cf=%b cp=%b want %b/%b", cf_pri, cp_pri, (COL_EN ? 6'b000010 : 6'b0), COL_EN); end
    tick();
    checks++; if (cp_pri !== 1'b0 || cf_pri !== (COL_EN ? 6'b000010 : 6'b0)) begin errors++; $display("FAIL b2b_after: got cf=%b cp=%b want %b/0", cf_pri, cp_pri, (COL_EN ? 6'b000010 : 6'b0)); end
  endtask

  initial begin
    test_reset();
    test_blend();
    test_override();
    test_collision();
    test_simultaneous();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/layer_compositor.md
# layer_compositor

Parametrised pixel compositor that replaces the fixed four-way OR of object, paddle, bullet and alien pixels feeding `hdmi_transmit`. It merges `NUM_LAYERS` sprite layers by fixed priority or legacy OR, applies a full-screen override (game-over screen), and registers the result through a two-stage pipeline. It also detects pixel-accurate overlap between every pair of layers and reports one hit bit per pair, latched once per frame at `fsync`. This gives the game logic a collision matrix that the bounding-box collision path cannot provide.

## Interface
Parameters:
- `NUM_LAYERS`, 4: number of sprite layers; legal range 2..8.
- `BLEND_MODE`, 0: 0 = priority (lowest index wins); 1 = bitwise OR of all active layers (legacy).
- `NUM_PAIRS`, NUM_LAYERS*(NUM_LAYERS-1)/2: derived; do not override.

Ports:
- `pixel_clk`  in  1  pixel clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fsync`  in  1  one-cycle frame-start pulse.
- `active`  in  1  active video region, aligned with the layer inputs.
- `layer_active`  in  NUM_LAYERS  per-layer "pixel drawn here" flag.
- `layer_pixel`  in  NUM_LAYERS*24  per-layer RGB; layer i is at bits [24i+23:24i], ordered {R[23:16],G[15:8],B[7:0]}.
- `override_en`  in  1  full-screen override select.
- `override_pixel`  in  24  override RGB.
- `pixel_out`  out  24  composited RGB.
- `collide_frame`  out  NUM_PAIRS  per-pair overlap bits from the previous frame.
- `collide_pulse`  out  1  one-cycle pulse when a new nonzero `collide_frame` is latched.

## Operation
- **Stage 1.** Register `active`, `layer_active`, `layer_pixel`, `override_en` and `override_pixel`.
- **Stage 2.** Compute and register `pixel_out`:
  - If the stage-1 `override_en` is 1: `override_pixel`.
  - Else if the stage-1 `active` is 0: 0.
  - Else with `BLEND_MODE`=0: the pixel of the lowest-index layer with `layer_active` set, or 0 if none is set.
  - Else with `BLEND_MODE`=1: bitwise OR of the pixels of all active layers. Inactive layers contribute 0 regardless of their `layer_pixel` value.
- **Collision.** Pair (i,j) with i<j is at index i*NUM_LAYERS - i*(i+1)/2 + (j-i-1).
  - An accumulator bit sets when the stage-1 `active` is 1 and `layer_active[i]` and `layer_active[j]` are both 1.
  - Accumulator bits are sticky until the next `fsync`.
- **Frame latch.** On a `pixel_clk` edge where the raw `fsync` is 1:
  - `collide_frame` <= accumulator OR the current stage-1 hit vector, so hits in the same cycle are included and none are lost.
  - The accumulator is cleared to 0. That same-cycle hit is not also carried into the new frame.
- `override_en` does not mask collision detection; overlap is tracked during the game-over screen.
- **Invalid parameter.** Elaboration fails via `$error` if `NUM_LAYERS` is outside 2..8.

## Timing
- Pixel latency is 2 cycles: inputs sampled at edge k appear on `pixel_out` after edge k+1. `hpos`/`vpos` must be pre-advanced by 2 cycles upstream.
- `collide_frame` updates on the `fsync` edge. `collide_pulse` goes high for exactly one cycle after that edge when the newly latched value is nonzero. It stays low for a frame with no hits.
- Back-to-back `fsync` pulses: each one latches and clears. The second latches only hits from the intervening stage-1 cycle.
- **Reset.** While `rst_n` is 0, asynchronously: all pipeline registers, `pixel_out`, the accumulator, `collide_frame` and `collide_pulse` are 0.
- **Reset mid-frame.** Accumulated hits are discarded. The first `fsync` after release latches only post-reset hits.
- **No fsync.** The accumulator saturates, with no wrap. `collide_frame` holds its value.

## Configuration
- **`LAYER_COMPOSITOR_COLLIDE_EN`** compiles the collision matrix in or out.
- **Defined:** the accumulator, frame latch and pulse operate as specified above.
- **Undefined:**
  - No accumulator or latch logic is generated.
  - `collide_frame` and `collide_pulse` are tied to 0.
  - Compositing and 2-cycle latency are unchanged.

## Test plan
- **Reset:** assert `rst_n`=0 mid-stream -> `pixel_out`=0, `collide_frame`=0 and `collide_pulse`=0 immediately, without waiting for a clock; first valid pixel appears 2 edges after inputs resume.
- **Priority:** `BLEND_MODE`=0, NUM_LAYERS=4, `layer_active`=4'b0110, layer1=0xFF0000, layer2=0x00FF00 -> `pixel_out`=0xFF0000 two cycles later. With `BLEND_MODE`=1 the same stimulus -> 0xFFFF00.
- **Override/blanking:** `override_en`=1 with 0x123456 -> 0x123456 regardless of layers. `active`=0, `override_en`=0 with layers on -> 0x000000.
- **Collision matrix:** layers 0 and 3 overlap for one pixel mid-frame, then `fsync` -> `collide_frame`=6'b000100 (pair index 2) and `collide_pulse` high for 1 cycle. The next `fsync` with no overlap -> `collide_frame`=0 and no pulse.
- **Simultaneous event:** overlap of layers 1 and 2 registered in stage 1 on the same edge as `fsync` -> bit 3 set in `collide_frame`. The following frame's `collide_frame` is 0 if there is no further overlap.
- **Macro off:** build without `LAYER_COMPOSITOR_COLLIDE_EN` and rerun the collision test -> `collide_frame`=0 and `collide_pulse`=0 throughout; pixel results are identical.
